// File: rtl/bch_eras_syndrome_count_pkg.sv
// Shared types, code parameters and GF(2^m) helpers for the erasure syndrome stage.
// Consumers: bch_eras_syndrome_acc, bch_eras_syndrome_count.
package bch_eras_syndrome_count_pkg;

  localparam int M      = 4;
  localparam int K_MAX  = 5;
  localparam int D      = 7;
  localparam int N      = 15;
  localparam int IRRPOL = 19;
  localparam int T      = (D - 1) / 2;
  localparam int T2     = 2 * T;
  localparam int PTR_W  = 4;
  localparam int GF_ORD = (1 << M) - 1;

  typedef logic [M-1:0]     data_t;
  typedef logic [PTR_W-1:0] ptr_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACC  = 1'b1
  } state_t;

  localparam data_t IRR_LOW = data_t'(IRRPOL);

  function automatic data_t gf_mult_a_by_b(input data_t a, input data_t b);
    data_t acc;
    data_t sh;
    acc = '0;
    sh  = a;
    for (int i = 0; i < M; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = sh[M-1] ? ((sh << 1) ^ IRR_LOW) : (sh << 1);
    end
    return acc;
  endfunction

  function automatic data_t alpha_pow(input int j);
    data_t p;
    int    e;
    p = data_t'(1);
    e = j % GF_ORD;
    for (int i = 0; i < GF_ORD; i++) begin
      if (i < e) p = gf_mult_a_by_b(p, data_t'(2));
    end
    return p;
  endfunction

  // Largest odd divisor of j, and the power of two that separates them.
  function automatic int odd_part(input int j);
    int v;
    v = j;
    for (int i = 0; i < 32; i++) begin
      if (v != 0 && v % 2 == 0) v = v / 2;
    end
    return v;
  endfunction

  function automatic int pow2_exp(input int j);
    int v;
    int k;
    v = j;
    k = 0;
    for (int i = 0; i < 32; i++) begin
      if (v != 0 && v % 2 == 0) begin
        v = v / 2;
        k = k + 1;
      end
    end
    return k;
  endfunction

  function automatic data_t gf_square_n(input data_t x, input int n_sq);
    data_t r;
    r = x;
    for (int i = 0; i < 8; i++) begin
      if (i < n_sq) r = gf_mult_a_by_b(r, r);
    end
    return r;
  endfunction

endpackage

// File: rtl/bch_eras_syndrome_acc.sv
// One Horner cell for syndrome S_j: acc <= sop ? bit : acc*alpha^j ^ bit.
// oacc presents the post-update value so the top can register it on eop.
module bch_eras_syndrome_acc
  import bch_eras_syndrome_count_pkg::*;
#(
  parameter int j = 1
) (
  input  logic  iclk,
  input  logic  ireset,
  input  logic  iclkena,
  input  logic  ival,
  input  logic  isop,
  input  logic  ibit,
  output data_t oacc
);

  localparam data_t ALPHA_J = alpha_pow(j);

  data_t acc;
  data_t acc_nxt;
  data_t bit_ext;

  assign bit_ext = {{(M-1){1'b0}}, ibit};

  always_comb begin
    acc_nxt = isop ? bit_ext : (gf_mult_a_by_b(acc, ALPHA_J) ^ bit_ext);
  end

  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset) begin
      acc <= '0;
    end else if (iclkena && ival) begin
      acc <= acc_nxt;
    end
  end

  assign oacc = acc_nxt;

endmodule

// File: rtl/bch_eras_syndrome_count.sv
// Bit-serial dual syndrome calculator (erased bits forced to 0 / forced to 1).
// Build option BCH_ERAS_SYNDROME_ODD_ONLY_EN: only odd S_j are accumulated, even ones by squaring.
//
// state   | meaning
// ST_IDLE | between frames; beats without isop are ignored
// ST_ACC  | inside a frame; valid beats feed the Horner cells
module bch_eras_syndrome_count
  import bch_eras_syndrome_count_pkg::*;
#(
  parameter int m      = M,
  parameter int k_max  = K_MAX,
  parameter int d      = D,
  parameter int n      = N,
  parameter int irrpol = IRRPOL
) (
  input  logic  iclk,
  input  logic  ireset,
  input  logic  iclkena,
  input  logic  ival,
  input  logic  isop,
  input  logic  ieop,
  input  logic  idat,
  input  logic  ieras,
  input  ptr_t  iptr,
  output logic  osyndrome_val,
  output ptr_t  osyndrome_ptr,
  output data_t osyndrome [2][1:T2]
);

  // Types are sized from the package, so overrides must agree with it.
  if (m != M || k_max != K_MAX || d != D || n != N || irrpol != IRRPOL) begin : g_cfg_check
    $error("bch_eras_syndrome_count: parameters must match bch_eras_syndrome_count_pkg");
  end

  state_t     state;
  state_t     state_nxt;
  logic       acc_ena;
  logic       frame_end;
  ptr_t       ptr_latched;
  logic [1:0] set_bit;
  data_t      syn_nxt [2][1:T2];

  assign set_bit[0] = idat & ~ieras;
  assign set_bit[1] = idat | ieras;

  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset) begin
      state <= ST_IDLE;
    end else if (iclkena) begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    acc_ena   = 1'b0;
    frame_end = 1'b0;
    if (ival) begin
      if (isop) begin
        acc_ena   = 1'b1;
        frame_end = ieop;
        state_nxt = ieop ? ST_IDLE : ST_ACC;
      end else if (state == ST_ACC) begin
        acc_ena = 1'b1;
        if (ieop) begin
          frame_end = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
    end
  end

  for (genvar s = 0; s < 2; s++) begin : g_set
`ifdef BCH_ERAS_SYNDROME_ODD_ONLY_EN
    data_t syn_odd [T];

    for (genvar i = 0; i < T; i++) begin : g_odd
      bch_eras_syndrome_acc #(.j(2 * i + 1)) u_acc (
        .iclk    (iclk),
        .ireset  (ireset),
        .iclkena (iclkena),
        .ival    (acc_ena),
        .isop    (isop),
        .ibit    (set_bit[s]),
        .oacc    (syn_odd[i])
      );
    end

    // S_j = S_odd^(2^k) with j = odd * 2^k; odd j pass through unsquared.
    for (genvar jj = 1; jj <= T2; jj++) begin : g_out
      localparam int ODD = odd_part(jj);
      localparam int SQ  = pow2_exp(jj);
      assign syn_nxt[s][jj] = gf_square_n(syn_odd[(ODD - 1) / 2], SQ);
    end
`else
    for (genvar jj = 1; jj <= T2; jj++) begin : g_all
      bch_eras_syndrome_acc #(.j(jj)) u_acc (
        .iclk    (iclk),
        .ireset  (ireset),
        .iclkena (iclkena),
        .ival    (acc_ena),
        .isop    (isop),
        .ibit    (set_bit[s]),
        .oacc    (syn_nxt[s][jj])
      );
    end
`endif
  end

  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset) begin
      osyndrome_val <= 1'b0;
      osyndrome_ptr <= '0;
      ptr_latched   <= '0;
      for (int s = 0; s < 2; s++) begin
        for (int jj = 1; jj <= T2; jj++) begin
          osyndrome[s][jj] <= '0;
        end
      end
    end else if (iclkena) begin
      osyndrome_val <= frame_end;
      if (ival && isop) begin
        ptr_latched <= iptr;
      end
      if (frame_end) begin
        // A one-bit frame has not latched its pointer yet.
        osyndrome_ptr <= isop ? iptr : ptr_latched;
        osyndrome     <= syn_nxt;
      end
    end
  end

endmodule

// File: tb/tb_bch_eras_syndrome_count.sv
// Bench for bch_eras_syndrome_count: table vectors, hand corner sequences, random frames
// checked against a direct polynomial-evaluation model.
module tb_bch_eras_syndrome_count;
  import bch_eras_syndrome_count_pkg::*;

  logic  iclk = 1'b0;
  logic  ireset = 1'b0;
  logic  iclkena = 1'b1;
  logic  ival = 1'b0;
  logic  isop = 1'b0;
  logic  ieop = 1'b0;
  logic  idat = 1'b0;
  logic  ieras = 1'b0;
  ptr_t  iptr = '0;
  logic  osyndrome_val;
  ptr_t  osyndrome_ptr;
  data_t osyndrome [2][1:T2];

  bch_eras_syndrome_count dut (
    .iclk          (iclk),
    .ireset        (ireset),
    .iclkena       (iclkena),
    .ival          (ival),
    .isop          (isop),
    .ieop          (ieop),
    .idat          (idat),
    .ieras         (ieras),
    .iptr          (iptr),
    .osyndrome_val (osyndrome_val),
    .osyndrome_ptr (osyndrome_ptr),
    .osyndrome     (osyndrome)
  );

  always #5 iclk = ~iclk;

  typedef logic [T2-1:0][M-1:0] syn_set_t;
  typedef struct packed {
    ptr_t     ptr;
    syn_set_t s0;
    syn_set_t s1;
  } exp_t;

  typedef struct {
    int          len;
    logic [14:0] dat;
    logic [14:0] eras;
    ptr_t        ptr;
    syn_set_t    e0;
    syn_set_t    e1;
  } vec_t;

  int    tests = 0;
  int    fails = 0;
  int    strobes = 0;
  int    pushed = 0;
  exp_t  exp_q[$];
  data_t exp_tab [15];
  logic  in_frame = 1'b0;
  ptr_t  fptr = '0;
  logic  b0_q[$];
  logic  b1_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // S_j = sum of r_i * alpha^(i*j); the first bit of an L-bit frame is r_(L-1).
  function automatic syn_set_t model_syn(input logic q[$]);
    syn_set_t r;
    int       len;
    r   = '0;
    len = q.size();
    for (int jj = 1; jj <= T2; jj++) begin
      for (int k = 0; k < len; k++) begin
        if (q[k]) r[jj-1] = r[jj-1] ^ exp_tab[((len - 1 - k) * jj) % 15];
      end
    end
    return r;
  endfunction

  function automatic syn_set_t dut_set(input int s);
    syn_set_t r;
    for (int jj = 1; jj <= T2; jj++) r[jj-1] = osyndrome[s][jj];
    return r;
  endfunction

  task automatic model_beat(input logic sop, input logic eop, input logic dat,
                            input logic eras, input ptr_t ptr);
    exp_t e;
    if (sop) begin
      b0_q.delete();
      b1_q.delete();
      in_frame = 1'b1;
      fptr     = ptr;
    end
    if (in_frame) begin
      b0_q.push_back(dat & ~eras);
      b1_q.push_back(dat | eras);
      if (eop) begin
        e.ptr = fptr;
        e.s0  = model_syn(b0_q);
        e.s1  = model_syn(b1_q);
        exp_q.push_back(e);
        pushed++;
        in_frame = 1'b0;
      end
    end
  endtask

  task automatic beat(input logic v, input logic sop, input logic eop, input logic dat,
                      input logic eras, input ptr_t ptr, input logic ena = 1'b1);
    ival    = v;
    isop    = sop;
    ieop    = eop;
    idat    = dat;
    ieras   = eras;
    iptr    = ptr;
    iclkena = ena;
    if (ena && v) model_beat(sop, eop, dat, eras, ptr);
    @(posedge iclk);
    #1;
  endtask

  task automatic idle(input int cnt);
    for (int i = 0; i < cnt; i++) beat(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic send_frame(input int len, input logic [14:0] dat, input logic [14:0] eras,
                            input ptr_t ptr);
    for (int k = 0; k < len; k++) begin
      beat(1'b1, k == 0, k == len - 1, dat[k], eras[k], ptr);
    end
  endtask

  // Scoreboard: each strobe is counted on the negedge of its final enabled cycle.
  always @(negedge iclk) begin
    if (!ireset && iclkena && osyndrome_val) begin
      exp_t e;
      strobes++;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL extra_strobe: got strobe with ptr %0h, expected none", osyndrome_ptr);
      end else begin
        e = exp_q.pop_front();
        check("sb_ptr", 64'(osyndrome_ptr), 64'(e.ptr));
        check("sb_set0", 64'(dut_set(0)), 64'(e.s0));
        check("sb_set1", 64'(dut_set(1)), 64'(e.s1));
      end
    end
  end

  vec_t vecs [5];

  initial begin
    data_t v;
    int    s0;
    v = data_t'(1);
    for (int e = 0; e < 15; e++) begin
      exp_tab[e] = v;
      v = v[M-1] ? ((v << 1) ^ data_t'(4'h3)) : (v << 1);
    end

    vecs[0] = '{15, 15'h0000, 15'h0000, ptr_t'(5),  '0, '0};
    vecs[1] = '{15, 15'h4000, 15'h0000, ptr_t'(3),  {6{4'd1}}, {6{4'd1}}};
    vecs[2] = '{15, 15'h2000, 15'h0000, ptr_t'(9),
                {4'd12, 4'd6, 4'd3, 4'd8, 4'd4, 4'd2}, {4'd12, 4'd6, 4'd3, 4'd8, 4'd4, 4'd2}};
    vecs[3] = '{15, 15'h0000, 15'h4000, ptr_t'(12), '0, {6{4'd1}}};
    vecs[4] = '{15, 15'h0000, 15'h2000, ptr_t'(7),  '0, {4'd12, 4'd6, 4'd3, 4'd8, 4'd4, 4'd2}};

    #2 ireset = 1'b1;
    @(posedge iclk);
    #1;
    check("rst_val", 64'(osyndrome_val), 64'(0));
    check("rst_ptr", 64'(osyndrome_ptr), 64'(0));
    check("rst_set0", 64'(dut_set(0)), 64'(0));
    check("rst_set1", 64'(dut_set(1)), 64'(0));
    @(posedge iclk);
    #1;
    ireset = 1'b0;
    idle(2);

    for (int i = 0; i < 5; i++) begin
      send_frame(vecs[i].len, vecs[i].dat, vecs[i].eras, vecs[i].ptr);
      check("vec_val", 64'(osyndrome_val), 64'(1));
      check("vec_ptr", 64'(osyndrome_ptr), 64'(vecs[i].ptr));
      check("vec_set0", 64'(dut_set(0)), 64'(vecs[i].e0));
      check("vec_set1", 64'(dut_set(1)), 64'(vecs[i].e1));
      idle(1);
      check("vec_pulse", 64'(osyndrome_val), 64'(0));
    end

    // iclkena low stretches the strobe
    send_frame(3, 15'h0005, 15'h0002, ptr_t'(10));
    beat(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    check("stretch_1", 64'(osyndrome_val), 64'(1));
    beat(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, ptr_t'(15), 1'b0);
    check("stretch_2", 64'(osyndrome_val), 64'(1));
    idle(1);
    check("stretch_end", 64'(osyndrome_val), 64'(0));
    idle(2);

    // stray beat in idle, gaps, restart, back-to-back frames
    s0 = strobes;
    beat(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, ptr_t'(6));
    beat(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, ptr_t'(2));
    beat(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, ptr_t'(2));
    beat(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ptr_t'(2));
    beat(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, ptr_t'(2), 1'b0);
    beat(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, ptr_t'(0));
    for (int k = 0; k < 8; k++) begin
      beat(1'b1, 1'b0, k == 7, 1'($urandom), 1'($urandom_range(0, 3) == 0), ptr_t'(0));
      if (k % 3 == 1) beat(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, ptr_t'(0));
    end
    beat(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, ptr_t'(1));
    for (int k = 0; k < 5; k++) begin
      beat(1'b1, 1'b0, k == 4, 1'($urandom), 1'($urandom), ptr_t'(1));
    end
    idle(2);
    check("b2b_strobes", 64'(strobes - s0), 64'(2));

    // reset mid-frame aborts it
    s0 = strobes;
    beat(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, ptr_t'(4));
    for (int k = 0; k < 4; k++) beat(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, ptr_t'(4));
    ireset   = 1'b1;
    in_frame = 1'b0;
    @(posedge iclk);
    #1;
    check("midrst_val", 64'(osyndrome_val), 64'(0));
    check("midrst_set1", 64'(dut_set(1)), 64'(0));
    ireset = 1'b0;
    beat(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, ptr_t'(4));
    idle(1);
    send_frame(9, 15'(($urandom)), 15'(($urandom)), ptr_t'(7));
    idle(2);
    check("rst_strobes", 64'(strobes - s0), 64'(1));

    // random frames
    for (int i = 0; i < 400; i++) begin
      beat(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 9) == 0),
           1'($urandom_range(0, 7) == 0), 1'($urandom), 1'($urandom_range(0, 4) == 0),
           ptr_t'($urandom_range(0, 15)), 1'($urandom_range(0, 9) != 0));
    end
    idle(3);

    check("pending", 64'(exp_q.size()), 64'(0));
    check("strobe_cnt", 64'(strobes), 64'(pushed));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
